// File: rtl/sync_fifo_if.sv
// ============================================================================
// Module      : sync_fifo_if
// Description : Handshake, data and status bundle for sync_fifo. The producer
//               and consumer side uses the master modport. The FIFO uses the
//               slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) ();
    logic                  clear;
    logic                  wen;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ren;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, wen, data_in, ren,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, wen, data_in, ren,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock parametrised FIFO. It has an occupancy count,
//               almost-full and almost-empty thresholds, sticky error flags
//               and a synchronous flush. Define SYNC_FIFO_FWFT_EN to select
//               first-word-fall-through read mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int AF_LEVEL   = 28,
    parameter int AE_LEVEL   = 4
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    sync_fifo_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] c_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] c_AF  = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_AE  = AE_LEVEL[ADDR_WIDTH:0];

    if (DEPTH != (1 << ADDR_WIDTH) || DEPTH < 4) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two >= 4 equal to 2**ADDR_WIDTH");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q,  count_d;
    logic                ovf_q,    ovf_d;
    logic                unf_q,    unf_d;

    logic w_full, w_empty, w_wr_acc, w_rd_acc;

    // Wrap bits differ and addresses match only when the writer is a full lap ahead.
    assign w_full   = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                      (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign w_empty  = (wr_ptr_q == rd_ptr_q);
    assign w_wr_acc = bus.wen && !w_full  && !bus.clear;
    assign w_rd_acc = bus.ren && !w_empty && !bus.clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (bus.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (w_wr_acc) wr_ptr_d = wr_ptr_q + c_ONE;
            if (w_rd_acc) rd_ptr_d = rd_ptr_q + c_ONE;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   count_d = count_q + c_ONE;
                2'b01:   count_d = count_q - c_ONE;
                default: count_d = count_q;
            endcase
            if (bus.wen && w_full)  ovf_d = 1'b1;
            if (bus.ren && w_empty) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.data_out = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
`else
    logic [DATA_WIDTH-1:0] dout_q;

    // A same-address write in this cycle lands after the read, so the old word is returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        dout_q <= '0;
        else if (w_rd_acc) dout_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    assign bus.data_out = dout_q;
`endif

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (count_q >= c_AF);
    assign bus.almost_empty = (count_q <= c_AE);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo. A queue-based reference
//               model is compared with the DUT on every cycle. The bench
//               also runs directed and randomised sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int AF    = 28;
    localparam int AE    = 4;

    logic clk;
    logic rst_n;
    logic chk_en;

    int n_tests;
    int n_fail;

    sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sync_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents, sticky flags and the registered read word.
    logic [DW-1:0] mq[$];
    logic          m_ovf;
    logic          m_unf;
    logic [DW-1:0] m_dout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = '0;
        end else if (bus.clear) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            automatic bit wacc = bus.wen && (mq.size() < DEPTH);
            automatic bit racc = bus.ren && (mq.size() > 0);
            if (bus.wen && !wacc) m_ovf = 1'b1;
            if (bus.ren && !racc) m_unf = 1'b1;
            if (racc) m_dout = mq.pop_front();
            if (wacc) mq.push_back(bus.data_in);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            automatic int sz = mq.size();
            chk("m_count", int'(bus.count),        sz);
            chk("m_full",  int'(bus.full),         int'(sz == DEPTH));
            chk("m_empty", int'(bus.empty),        int'(sz == 0));
            chk("m_af",    int'(bus.almost_full),  int'(sz >= AF));
            chk("m_ae",    int'(bus.almost_empty), int'(sz <= AE));
            chk("m_ovf",   int'(bus.overflow),     int'(m_ovf));
            chk("m_unf",   int'(bus.underflow),    int'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
            if (sz != 0) chk("m_head", int'(bus.data_out), int'(mq[0]));
`else
            chk("m_dout",  int'(bus.data_out),     int'(m_dout));
`endif
        end
    end

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        bus.wen     = w;
        bus.data_in = d;
        bus.ren     = r;
        bus.clear   = c;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_count"}, int'(bus.count),        0);
        chk({nm, "_empty"}, int'(bus.empty),        1);
        chk({nm, "_full"},  int'(bus.full),         0);
        chk({nm, "_af"},    int'(bus.almost_full),  0);
        chk({nm, "_ae"},    int'(bus.almost_empty), 1);
        chk({nm, "_ovf"},   int'(bus.overflow),     0);
        chk({nm, "_unf"},   int'(bus.underflow),    0);
`ifndef SYNC_FIFO_FWFT_EN
        chk({nm, "_dout"},  int'(bus.data_out),     0);
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        rst_n   = 1'b0;
        bus.wen = 1'b0; bus.ren = 1'b0; bus.clear = 1'b0; bus.data_in = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fill with 0x00..0x1F; almost_full first rises after the 28th write.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, DW'(i), 1'b0, 1'b0);
            chk("fill_af", int'(bus.almost_full), int'(i + 1 >= 28));
        end
        chk("fill_full",  int'(bus.full),  1);
        chk("fill_count", int'(bus.count), 32);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_set",    int'(bus.overflow), 1);
        chk("ovf_count",  int'(bus.count),    32);

        // Drain; the rejected 33rd write must not appear.
        for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            chk("rd_seq", int'(bus.data_out), i);
            cyc(1'b0, '0, 1'b1, 1'b0);
`else
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("rd_seq", int'(bus.data_out), i);
`endif
        end
        chk("drain_empty", int'(bus.empty), 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("unf_set", int'(bus.underflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("unf_dout", int'(bus.data_out), 8'h1F);
`endif

        // Wrap-around across the pointer MSB.
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            chk("wrap_seq", int'(bus.data_out), 8'h40 + i);
            cyc(1'b0, '0, 1'b1, 1'b0);
`else
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("wrap_seq", int'(bus.data_out), 8'h40 + i);
`endif
        end
        chk("wrap_count", int'(bus.count), 0);

        // Simultaneous read and write at count 10, then at full.
        for (int i = 0; i < 10; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, DW'($urandom), 1'b1, 1'b0);
            chk("rw10_count", int'(bus.count), 10);
        end
        for (int i = 0; i < 22; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        chk("rwfull_count", int'(bus.count),    31);
        chk("rwfull_ovf",   int'(bus.overflow), 1);

        // Clear at count 17 with both sticky flags set, wen=ren=1.
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("pre_clr_count", int'(bus.count),     17);
        chk("pre_clr_ovf",   int'(bus.overflow),  1);
        chk("pre_clr_unf",   int'(bus.underflow), 1);
        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        chk("clr_count", int'(bus.count),     0);
        chk("clr_empty", int'(bus.empty),     1);
        chk("clr_ovf",   int'(bus.overflow),  0);
        chk("clr_unf",   int'(bus.underflow), 0);

        // Randomised traffic, alternating fill-biased and drain-biased blocks.
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 250; i++) begin
                automatic int wb = (b % 2 == 0) ? 70 : 30;
                cyc($urandom_range(0, 99) < wb, DW'($urandom),
                    $urandom_range(0, 99) < (100 - wb), $urandom_range(0, 199) == 0);
            end
        end

        // Asynchronous reset between edges at count 5.
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        chk("pre_rst_count", int'(bus.count), 5);
        bus.wen = 1'b0; bus.ren = 1'b0; bus.clear = 1'b0;
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // A word written into an empty FIFO.
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("a5_empty", int'(bus.empty), 0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("a5_fwft", int'(bus.data_out), 8'hA5);
`else
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("a5_read", int'(bus.data_out), 8'hA5);
`endif
        cyc(1'b0, '0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO (storage plus pointer/flag control) for same-domain buffering between pipeline stages. It generalises the dual-port FIFO memory with:
- internal pointer management and an occupancy count
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags and a synchronous flush
- a compile-time first-word-fall-through read mode

Parameters:
DATA_WIDTH, 8, word width in bits
DEPTH, 32, number of words; must be a power of two, >= 4
ADDR_WIDTH, 5, log2(DEPTH); pointers are ADDR_WIDTH+1 bits wide
AF_LEVEL, 28, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of pointers, count and error flags
wen  input  1  write request
data_in  input  DATA_WIDTH  write data
ren  input  1  read request
data_out  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=rd_ptr=0, count=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0, data_out=0. Memory array is not reset.
- Pointers: ADDR_WIDTH+1 bits. Low ADDR_WIDTH bits address memory. The MSB is a wrap bit.
  - full = (wr_ptr MSB != rd_ptr MSB) && (low bits equal).
  - empty = (wr_ptr == rd_ptr).
  - Both wrap naturally from DEPTH*2-1 to 0.
- Accept rules, evaluated on the current-cycle flags:
  - write accepted iff wen && !full && !clear
  - read accepted iff ren && !empty && !clear
- Write while full: rejected even if a read is accepted the same cycle. Memory and wr_ptr are unchanged; overflow set on the next edge.
- Read while empty: rejected. rd_ptr and data_out are unchanged; underflow set on the next edge.
- count update:
  - +1 on write-only accept
  - -1 on read-only accept
  - unchanged when both or neither are accepted
- Flags: all are combinational decodes of registered count/pointers, so they update in the cycle after the causing edge. There are no glitch paths from wen/ren to flags.
- Standard read mode:
  - data_out is registered, latency 1: on an accepted read at edge N, data_out = mem[rd_ptr] after edge N.
  - data_out holds its value otherwise.
- Simultaneous read and write at the same address (count==0 is impossible since the read is rejected): the read always returns the old word.
- clear:
  - Overrides wen/ren that cycle.
  - Next edge: pointers=0, count=0, overflow=underflow=0, flags to the reset pattern.
  - data_out is not cleared; memory is not cleared.
- Reset mid-operation: immediate return to reset values. Any in-flight write at that edge is lost.
- Parameter legality: AF_LEVEL/AE_LEVEL outside their ranges is a configuration error, flagged by a simulation-only elaboration check.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[rd_ptr low bits] continuously (asynchronous array read); the head word is valid whenever empty=0.
  - An accepted ren pops the head; the next word appears in the same cycle after the edge.
  - A word written at edge N into an empty FIFO is visible, with empty=0, after edge N.
  - data_out is don't-care while empty; reset value is irrelevant.
- Undefined: standard registered read mode as above.

Test Plan:
- Reset, then 32 writes of 0x00..0x1F with ren=0 -> full=1 and count=32 after the 32nd edge; almost_full first high after the 28th write; a 33rd write sets overflow=1 and leaves memory unchanged.
- Read 32 words from full -> data_out sequence 0x00..0x1F, each one cycle after its ren edge; empty=1 after the last; one further ren sets underflow=1 and data_out stays 0x1F.
- Wrap-around: write 20, read 20, write 20, read 20 (data 0x40..0x53 on the second pass) -> data in order, count 0, pointers crossed the MSB wrap with full never asserted.
- Simultaneous wen+ren at count=10 for 50 cycles -> count stays 10, almost flags constant, data in order; same at count=32 -> read accepted, write rejected, count becomes 31, overflow=1.
- clear asserted with wen=ren=1 at count=17 with both sticky flags set -> next cycle count=0, empty=1, overflow=underflow=0, no write occurred.
- Assert rst_n=0 asynchronously between edges at count=5 -> outputs take reset values immediately, without waiting for a clock edge. With SYNC_FIFO_FWFT_EN defined, write 0xA5 into an empty FIFO -> data_out=0xA5 and empty=0 after that edge, no ren needed.
